// File: rtl/fft_sched_pkg.sv
// Shared definitions for the FFT/IFFT job scheduler.
//   state_e      : scheduler FSM states
//   OWN_*        : job owner encoding (which requester a job belongs to)
//   MODE_*       : core mode encoding (0 = FFT, 1 = IFFT)
//   *_DEFAULT    : default frame geometry
package fft_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic OWN_RX    = 1'b0;
  localparam logic OWN_TX    = 1'b1;
  localparam logic MODE_FFT  = 1'b0;
  localparam logic MODE_IFFT = 1'b1;

  localparam int unsigned N_DEFAULT    = 64;
  localparam int unsigned RE_W_DEFAULT = 16;
  localparam int unsigned IM_W_DEFAULT = 16;

endpackage

// File: rtl/fft_sched_rr_arb.sv
// Two-input round-robin arbiter between the RX and TX requesters.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rx_req, tx_req  : request levels
//   upd, upd_owner  : record upd_owner as last-served when upd is high
//   winner          : OWN_RX / OWN_TX, valid whenever any is high
//   any             : at least one request is pending
module fft_sched_rr_arb
  import fft_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_req,
  input  logic tx_req,
  input  logic upd,
  input  logic upd_owner,
  output logic winner,
  output logic any
);

  logic last_q;

  // Resets to TX so that RX wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_TX;
    end else if (upd) begin
      last_q <= upd_owner;
    end
  end

  always_comb begin
    any    = rx_req | tx_req;
    winner = OWN_RX;
    if (rx_req && tx_req) begin
      winner = (last_q == OWN_TX) ? OWN_RX : OWN_TX;
    end else if (tx_req) begin
      winner = OWN_TX;
    end
  end

endmodule

// File: rtl/fft_ifft_sched.sv
// Shares one FFT/IFFT core between the RX (FFT) and TX (IFFT) requesters.
// Each job: latch the winner's frame and mode, pulse core_in_valid and the
// owner's gnt, wait for core_out_valid, capture the result, pulse done.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   rx_req/rx_re/rx_im/rx_gnt/rx_done : RX requester (FFT)
//   tx_req/tx_re/tx_im/tx_gnt/tx_done : TX requester (IFFT)
//   res_re, res_im               : result of the last completed job
//   core_mode, core_in_*, core_in_valid : registered job to the core
//   core_out_*, core_out_valid   : core result
//   busy                         : scheduler not idle
//   timeout_err                  : one-cycle watchdog pulse
// Optional feature: define FFT_SCHED_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT cycles); otherwise timeout_err is tied low.
module fft_ifft_sched
  import fft_sched_pkg::*;
#(
  parameter int unsigned N       = N_DEFAULT,
  parameter int unsigned RE_W    = RE_W_DEFAULT,
  parameter int unsigned IM_W    = IM_W_DEFAULT,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_req,
  input  logic [RE_W*N-1:0]   rx_re,
  input  logic [IM_W*N-1:0]   rx_im,
  output logic                rx_gnt,
  output logic                rx_done,
  input  logic                tx_req,
  input  logic [RE_W*N-1:0]   tx_re,
  input  logic [IM_W*N-1:0]   tx_im,
  output logic                tx_gnt,
  output logic                tx_done,
  output logic [RE_W*N-1:0]   res_re,
  output logic [IM_W*N-1:0]   res_im,
  output logic                core_mode,
  output logic [RE_W*N-1:0]   core_in_re,
  output logic [IM_W*N-1:0]   core_in_im,
  output logic                core_in_valid,
  input  logic [RE_W*N-1:0]   core_out_re,
  input  logic [IM_W*N-1:0]   core_out_im,
  input  logic                core_out_valid,
  output logic                busy,
  output logic                timeout_err
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [RE_W*N-1:0] in_re_d, res_re_d;
  logic [IM_W*N-1:0] in_im_d, res_im_d;
  logic              winner, any, upd;

  fft_sched_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .rx_req    (rx_req),
    .tx_req    (tx_req),
    .upd       (upd),
    .upd_owner (owner_q),
    .winner    (winner),
    .any       (any)
  );

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            terr_q, terr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    in_re_d  = core_in_re;
    in_im_d  = core_in_im;
    res_re_d = res_re;
    res_im_d = res_im;
    upd      = 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
    cnt_d  = cnt_q;
    terr_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (any) begin
          owner_d = winner;
          in_re_d = (winner == OWN_TX) ? tx_re : rx_re;
          in_im_d = (winner == OWN_TX) ? tx_im : rx_im;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef FFT_SCHED_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      StWait: begin
        if (core_out_valid) begin
          res_re_d = core_out_re;
          res_im_d = core_out_im;
          state_d  = StDone;
`ifdef FFT_SCHED_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          // Abandon the job; rotate priority as if it had completed.
          upd     = 1'b1;
          terr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        upd     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= OWN_RX;
      core_in_re <= '0;
      core_in_im <= '0;
      res_re     <= '0;
      res_im     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      core_in_re <= in_re_d;
      core_in_im <= in_im_d;
      res_re     <= res_re_d;
      res_im     <= res_im_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign core_in_valid = (state_q == StIssue);
  assign core_mode     = (owner_q == OWN_TX) ? MODE_IFFT : MODE_FFT;
  assign rx_gnt        = core_in_valid && (owner_q == OWN_RX);
  assign tx_gnt        = core_in_valid && (owner_q == OWN_TX);
  assign rx_done       = (state_q == StDone) && (owner_q == OWN_RX);
  assign tx_done       = (state_q == StDone) && (owner_q == OWN_TX);

endmodule

// File: tb/tb_fft_ifft_sched.sv
// Self-checking bench for fft_ifft_sched: a behavioural core model with
// programmable latency, a round-robin reference (last_tx) and expected
// results derived from the frames the bench itself submitted.
module tb_fft_ifft_sched;

  localparam int unsigned N          = 64;
  localparam int unsigned RE_W       = 16;
  localparam int unsigned IM_W       = 16;
  localparam int unsigned FW         = RE_W * N;
  localparam int unsigned TB_TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_req, tx_req;
  logic [FW-1:0] rx_re, rx_im, tx_re, tx_im;
  logic          rx_gnt, rx_done, tx_gnt, tx_done;
  logic [FW-1:0] res_re, res_im, core_in_re, core_in_im, core_out_re, core_out_im;
  logic          core_mode, core_in_valid, core_out_valid, busy, timeout_err;

  logic          mdl_valid, spur_valid, model_en;
  logic [FW-1:0] mdl_re, mdl_im, spur_re, spur_im;
  int            lat;
  int            cyc = 0;
  int            valid_cyc;
  int            n_chk = 0;
  int            n_fail = 0;
  logic          last_tx;         // reference last-served, 1 = TX
  logic [FW-1:0] ref_re, ref_im;  // reference contents of res_*

  assign core_out_valid = mdl_valid | spur_valid;
  assign core_out_re    = spur_valid ? spur_re : mdl_re;
  assign core_out_im    = spur_valid ? spur_im : mdl_im;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_ifft_sched #(
    .N       (N),
    .RE_W    (RE_W),
    .IM_W    (IM_W),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_req         (rx_req),
    .rx_re          (rx_re),
    .rx_im          (rx_im),
    .rx_gnt         (rx_gnt),
    .rx_done        (rx_done),
    .tx_req         (tx_req),
    .tx_re          (tx_re),
    .tx_im          (tx_im),
    .tx_gnt         (tx_gnt),
    .tx_done        (tx_done),
    .res_re         (res_re),
    .res_im         (res_im),
    .core_mode      (core_mode),
    .core_in_re     (core_in_re),
    .core_in_im     (core_in_im),
    .core_in_valid  (core_in_valid),
    .core_out_re    (core_out_re),
    .core_out_im    (core_out_im),
    .core_out_valid (core_out_valid),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  // Stand-in core transform: easy to predict, differs between modes.
  function automatic logic [FW-1:0] core_fn_re(input logic [FW-1:0] re, input logic [FW-1:0] im,
                                               input logic mode);
    return mode ? ~im : (im ^ re);
  endfunction

  task automatic gen_frame(output logic [FW-1:0] re, output logic [FW-1:0] im);
    for (int i = 0; i < int'(FW / 32); i++) begin
      re[i*32 +: 32] = $urandom;
      im[i*32 +: 32] = $urandom;
    end
  endtask

  // Core model: result strobe lat cycles after the start pulse.
  initial begin
    logic [FW-1:0] m_re, m_im;
    logic          m_mode;
    mdl_valid = 1'b0;
    mdl_re    = '0;
    mdl_im    = '0;
    valid_cyc = -100;
    forever begin
      @(negedge clk);
      mdl_valid = 1'b0;
      if (core_in_valid === 1'b1 && model_en) begin
        m_re   = core_in_re;
        m_im   = core_in_im;
        m_mode = core_mode;
        repeat (lat - 1) @(negedge clk);
        mdl_re    = core_fn_re(m_re, m_im, m_mode);
        mdl_im    = m_re;
        mdl_valid = 1'b1;
        valid_cyc = cyc;
      end
    end
  end

  task automatic apply_reset();
    rst    = 1'b1;
    rx_req = 1'b0;
    tx_req = 1'b0;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    last_tx = 1'b1;
    ref_re  = '0;
    ref_im  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, rx_gnt, tx_gnt, rx_done, tx_done, core_in_valid, core_mode, timeout_err} !== 8'h00)
    begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {busy, rx_gnt, tx_gnt, rx_done, tx_done, core_in_valid, core_mode, timeout_err});
    end
    n_chk++;
    if (res_re !== '0 || res_im !== '0) begin
      n_fail++;
      $display("FAIL reset_res: got re[63:0]=%h im[63:0]=%h want 0", res_re[63:0], res_im[63:0]);
    end
    n_chk++;
    if (core_in_re !== '0 || core_in_im !== '0) begin
      n_fail++;
      $display("FAIL reset_core_in: got re[63:0]=%h want 0", core_in_re[63:0]);
    end
    rst     = 1'b0;
    last_tx = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || core_in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b valid=%b want 0 0", busy, core_in_valid);
    end
  endtask

  task automatic test_single_rx();
    logic [FW-1:0] fre, fim, got_re, got_im;
    int            done_cyc, n_rxd, n_tx;
    fre       = '0;
    fre[15:0] = 16'h0100;
    fim       = '0;
    rx_re     = fre;
    rx_im     = fim;
    lat       = 10;
    rx_req    = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({rx_gnt, core_in_valid, core_mode, tx_gnt} !== 4'b1100) begin
      n_fail++;
      $display("FAIL single_issue: gnt/valid/mode/txgnt=%b want 1100",
               {rx_gnt, core_in_valid, core_mode, tx_gnt});
    end
    n_chk++;
    if (core_in_re !== fre || core_in_im !== fim) begin
      n_fail++;
      $display("FAIL single_core_in: got %h want %h", core_in_re[63:0], fre[63:0]);
    end
    rx_req   = 1'b0;
    done_cyc = -1;
    n_rxd    = 0;
    n_tx     = 0;
    got_re   = '0;
    got_im   = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_gnt === 1'b1 || tx_done === 1'b1) n_tx++;
      if (rx_done === 1'b1) begin
        n_rxd++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          got_re   = res_re;
          got_im   = res_im;
        end
      end
    end
    ref_re  = core_fn_re(fre, fim, 1'b0);
    ref_im  = fre;
    last_tx = 1'b0;
    n_chk++;
    if (n_rxd != 1) begin
      n_fail++;
      $display("FAIL single_done_count: got %0d want 1", n_rxd);
    end
    n_chk++;
    if (done_cyc != valid_cyc + 1) begin
      n_fail++;
      $display("FAIL single_done_latency: done at %0d want %0d", done_cyc, valid_cyc + 1);
    end
    n_chk++;
    if (got_re !== ref_re || got_im !== ref_im) begin
      n_fail++;
      $display("FAIL single_result: got %h want %h", got_re[63:0], ref_re[63:0]);
    end
    n_chk++;
    if (n_tx != 0) begin
      n_fail++;
      $display("FAIL single_tx_quiet: %0d tx pulses want 0", n_tx);
    end
  endtask

  task automatic test_tie_after_reset();
    logic [FW-1:0] fr_re, fr_im, ft_re, ft_im;
    int            w;
    apply_reset();
    gen_frame(fr_re, fr_im);
    gen_frame(ft_re, ft_im);
    rx_re  = fr_re;
    rx_im  = fr_im;
    tx_re  = ft_re;
    tx_im  = ft_im;
    lat    = 6;
    rx_req = 1'b1;
    tx_req = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({rx_gnt, tx_gnt, core_mode} !== 3'b100 || core_in_re !== fr_re) begin
      n_fail++;
      $display("FAIL tie_first: rx/tx gnt,mode=%b want 100", {rx_gnt, tx_gnt, core_mode});
    end
    rx_req = 1'b0;
    w = 0;
    while (rx_done !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (rx_done !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_rx_done: rx_done=%b after %0d cycles want 1", rx_done, w);
    end
    last_tx = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({rx_gnt, tx_gnt, core_in_valid, core_mode} !== 4'b0111) begin
      n_fail++;
      $display("FAIL tie_tx_issue: rxg/txg/valid/mode=%b want 0111",
               {rx_gnt, tx_gnt, core_in_valid, core_mode});
    end
    n_chk++;
    if (core_in_re !== ft_re || core_in_im !== ft_im) begin
      n_fail++;
      $display("FAIL tie_tx_frame: got %h want %h", core_in_re[63:0], ft_re[63:0]);
    end
    tx_req = 1'b0;
    w = 0;
    while (tx_done !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    ref_re  = core_fn_re(ft_re, ft_im, 1'b1);
    ref_im  = ft_re;
    last_tx = 1'b1;
    n_chk++;
    if (tx_done !== 1'b1 || res_re !== ref_re || res_im !== ref_im) begin
      n_fail++;
      $display("FAIL tie_tx_result: done=%b res %h want %h", tx_done, res_re[63:0], ref_re[63:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_continuous_tie();
    logic          exp_own;
    logic [FW-1:0] e_re, e_im;
    int            w, idle;
    gen_frame(rx_re, rx_im);
    gen_frame(tx_re, tx_im);
    lat    = $urandom_range(3, 12);
    rx_req = 1'b1;
    tx_req = 1'b1;
    for (int j = 0; j < 6; j++) begin
      exp_own = (rx_req && tx_req) ? ~last_tx : tx_req;
      e_re    = exp_own ? tx_re : rx_re;
      e_im    = exp_own ? tx_im : rx_im;
      w = 0;
      while (core_in_valid !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      n_chk++;
      if (core_in_valid !== 1'b1 || {rx_gnt, tx_gnt, core_mode} !== {~exp_own, exp_own, exp_own})
      begin
        n_fail++;
        $display("FAIL cont_owner job %0d: valid=%b rxg/txg/mode=%b want owner %0d", j,
                 core_in_valid, {rx_gnt, tx_gnt, core_mode}, exp_own);
      end
      if (exp_own) tx_req = 1'b0;
      else rx_req = 1'b0;
      @(negedge clk);
      if (j < 4) begin
        if (exp_own) begin
          gen_frame(tx_re, tx_im);
          tx_req = 1'b1;
        end else begin
          gen_frame(rx_re, rx_im);
          rx_req = 1'b1;
        end
      end
      w = 0;
      while (rx_done !== 1'b1 && tx_done !== 1'b1 && w < 40) begin
        @(negedge clk);
        w++;
      end
      ref_re  = core_fn_re(e_re, e_im, exp_own);
      ref_im  = e_re;
      last_tx = exp_own;
      lat     = $urandom_range(3, 12);
      n_chk++;
      if ({rx_done, tx_done} !== {~exp_own, exp_own} || res_re !== ref_re || res_im !== ref_im)
      begin
        n_fail++;
        $display("FAIL cont_done job %0d: rx/tx done=%b res %h want owner %0d res %h", j,
                 {rx_done, tx_done}, res_re[63:0], exp_own, ref_re[63:0]);
      end
      n_chk++;
      if (core_in_re !== e_re || core_in_im !== e_im) begin
        n_fail++;
        $display("FAIL cont_frozen job %0d: core_in %h want %h", j, core_in_re[63:0], e_re[63:0]);
      end
      if (j < 5) begin
        idle = 0;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (busy === 1'b1) break;
          idle++;
        end
        n_chk++;
        if (idle != 1) begin
          n_fail++;
          $display("FAIL cont_idle_gap job %0d: %0d idle cycles want 1", j, idle);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_spurious_strobe();
    logic [FW-1:0] fre, fim;
    int            w;
    gen_frame(spur_re, spur_im);
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || rx_done !== 1'b0 || tx_done !== 1'b0 || res_re !== ref_re ||
        res_im !== ref_im) begin
      n_fail++;
      $display("FAIL spur_idle: busy=%b done=%b%b res %h want idle, no done, res %h", busy,
               rx_done, tx_done, res_re[63:0], ref_re[63:0]);
    end
    gen_frame(fre, fim);
    rx_re  = fre;
    rx_im  = fim;
    lat    = 8;
    rx_req = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rx_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_issue_gnt: rx_gnt=%b want 1", rx_gnt);
    end
    rx_req = 1'b0;
    gen_frame(spur_re, spur_im);
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || rx_done !== 1'b0 || res_re !== ref_re || res_im !== ref_im) begin
      n_fail++;
      $display("FAIL spur_issue: busy=%b rx_done=%b res %h want 1 0 res %h", busy, rx_done,
               res_re[63:0], ref_re[63:0]);
    end
    w = 0;
    while (rx_done !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    ref_re  = core_fn_re(fre, fim, 1'b0);
    ref_im  = fre;
    last_tx = 1'b0;
    n_chk++;
    if (rx_done !== 1'b1 || cyc != valid_cyc + 1 || res_re !== ref_re || res_im !== ref_im) begin
      n_fail++;
      $display("FAIL spur_job_result: done=%b at %0d (strobe %0d) res %h want %h", rx_done, cyc,
               valid_cyc, res_re[63:0], ref_re[63:0]);
    end
    @(negedge clk);
  endtask

`ifdef FFT_SCHED_TIMEOUT_EN
  task automatic test_watchdog();
    logic [FW-1:0] fre, fim;
    int            w, nd;
    model_en = 1'b0;
    gen_frame(rx_re, rx_im);
    rx_req = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rx_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_issue: rx_gnt=%b want 1", rx_gnt);
    end
    rx_req = 1'b0;
    w  = 0;
    nd = 0;
    while (timeout_err !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
      if (rx_done === 1'b1 || tx_done === 1'b1) nd++;
    end
    n_chk++;
    if (w != TB_TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL wd_delay: timeout_err after %0d cycles want %0d", w, TB_TIMEOUT + 1);
    end
    n_chk++;
    if (busy !== 1'b0 || nd != 0) begin
      n_fail++;
      $display("FAIL wd_abort: busy=%b dones=%0d want 0 0", busy, nd);
    end
    @(negedge clk);
    n_chk++;
    if (timeout_err !== 1'b0 || res_re !== ref_re) begin
      n_fail++;
      $display("FAIL wd_pulse: timeout_err=%b res %h want 0 res %h", timeout_err, res_re[63:0],
               ref_re[63:0]);
    end
    last_tx  = 1'b0;
    model_en = 1'b1;
    gen_frame(fre, fim);
    rx_re  = fre;
    rx_im  = fim;
    lat    = 5;
    rx_req = 1'b1;
    @(negedge clk);
    rx_req = 1'b0;
    w = 0;
    while (rx_done !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    ref_re = core_fn_re(fre, fim, 1'b0);
    ref_im = fre;
    n_chk++;
    if (rx_done !== 1'b1 || res_re !== ref_re || res_im !== ref_im) begin
      n_fail++;
      $display("FAIL wd_recover: done=%b res %h want 1 res %h", rx_done, res_re[63:0],
               ref_re[63:0]);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_job();
    int nd;
    gen_frame(tx_re, tx_im);
    lat    = 10;
    tx_req = 1'b1;
    @(negedge clk);
    n_chk++;
    if (tx_gnt !== 1'b1 || core_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_issue: tx_gnt=%b mode=%b want 1 1", tx_gnt, core_mode);
    end
    tx_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    last_tx = 1'b1;
    ref_re  = '0;
    ref_im  = '0;
    n_chk++;
    if ({busy, rx_gnt, tx_gnt, rx_done, tx_done, core_in_valid, core_mode, timeout_err} !== 8'h00)
    begin
      n_fail++;
      $display("FAIL mid_reset_ctrl: got %b want 00000000",
               {busy, rx_gnt, tx_gnt, rx_done, tx_done, core_in_valid, core_mode, timeout_err});
    end
    n_chk++;
    if (core_in_re !== '0 || core_in_im !== '0 || res_re !== '0 || res_im !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_data: core_in %h res %h want 0", core_in_re[63:0], res_re[63:0]);
    end
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rx_done === 1'b1 || tx_done === 1'b1) nd++;
    end
    n_chk++;
    if (nd != 0 || busy !== 1'b0 || res_re !== '0) begin
      n_fail++;
      $display("FAIL mid_late_strobe: dones=%0d busy=%b res %h want 0 0 0", nd, busy,
               res_re[63:0]);
    end
  endtask

  initial begin
    rst        = 1'b1;
    rx_req     = 1'b0;
    tx_req     = 1'b0;
    rx_re      = '0;
    rx_im      = '0;
    tx_re      = '0;
    tx_im      = '0;
    spur_valid = 1'b0;
    spur_re    = '0;
    spur_im    = '0;
    model_en   = 1'b1;
    lat        = 10;
    last_tx    = 1'b1;
    ref_re     = '0;
    ref_im     = '0;
    test_reset();
    test_single_rx();
    test_tie_after_reset();
    test_continuous_tie();
    test_spurious_strobe();
`ifdef FFT_SCHED_TIMEOUT_EN
    test_watchdog();
`endif
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
